// File: rtl/cmd_rsp_receiver.sv
// SD-card CMD-line response receiver: waits for a start bit, shifts in a 48- or 136-bit
// response, checks CRC7, command index and framing, and holds the result until re-armed.
module cmd_rsp_receiver (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clk_en_i,
    input  logic         start_listen_i,
    input  logic         long_rsp_i,
    input  logic         no_crc_i,
    input  logic [5:0]   cmd_index_i,
    input  logic         rsp_ser_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [127:0] rsp_o,
    output logic         crc_err_o,
    output logic         index_err_o,
    output logic         frame_err_o,
    output logic         timeout_o
);

    typedef enum logic [1:0] {IDLE, WAIT_START, RECEIVE, DONE} state_e;

    state_e         state_q, state_d;
    logic           long_q, long_d;
    logic           no_crc_q, no_crc_d;
    logic [5:0]     cmd_idx_q, cmd_idx_d;
    logic [7:0]     bit_cnt_q, bit_cnt_d;
    logic [5:0]     tmo_cnt_q, tmo_cnt_d;
    logic [6:0]     crc_q, crc_d;
    logic [126:0]   sr_q, sr_d;
    logic           trans_err_q, trans_err_d;
    logic [127:0]   rsp_q, rsp_d;
    logic           crc_err_q, crc_err_d;
    logic           index_err_q, index_err_d;
    logic           frame_err_q, frame_err_d;
    logic           timeout_q, timeout_d;
    logic           fb;
    logic [6:0]     crc_next;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
        state_d     = state_q;
        long_d      = long_q;
        no_crc_d    = no_crc_q;
        cmd_idx_d   = cmd_idx_q;
        bit_cnt_d   = bit_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        crc_d       = crc_q;
        sr_d        = sr_q;
        trans_err_d = trans_err_q;
        rsp_d       = rsp_q;
        crc_err_d   = crc_err_q;
        index_err_d = index_err_q;
        frame_err_d = frame_err_q;
        timeout_d   = timeout_q;

        fb       = rsp_ser_i ^ crc_q[6];
        crc_next = {crc_q[5:3], crc_q[2] ^ fb, crc_q[1:0], fb};

        if (clk_en_i) begin
            case (state_q)
                IDLE, DONE: begin
                    if (state_q == DONE) state_d = IDLE;
                    if (start_listen_i) begin
                        state_d     = WAIT_START;
                        long_d      = long_rsp_i;
                        no_crc_d    = no_crc_i;
                        cmd_idx_d   = cmd_index_i;
                        bit_cnt_d   = '0;
                        tmo_cnt_d   = '0;
                        crc_d       = '0;
                        sr_d        = '0;
                        trans_err_d = 1'b0;
                        rsp_d       = '0;
                        crc_err_d   = 1'b0;
                        index_err_d = 1'b0;
                        frame_err_d = 1'b0;
                        timeout_d   = 1'b0;
                    end
                end
                WAIT_START: begin
                    if (!rsp_ser_i) begin
                        state_d   = RECEIVE;
                        bit_cnt_d = long_q ? 8'd134 : 8'd46;
                        // The start bit is part of the CRC only for 48-bit responses.
                        if (!long_q) crc_d = crc_next;
                    end else if (tmo_cnt_q == 6'd63) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 6'd1;
                    end
                end
                RECEIVE: begin
                    if (bit_cnt_q == 8'd0) begin
                        // sr_q now holds frame bits [127:1] (long) or [46:1] (short) in its low end.
                        state_d     = DONE;
                        rsp_d       = long_q ? {8'b0, sr_q[126:7]} : {96'b0, sr_q[38:7]};
                        crc_err_d   = !no_crc_q && (crc_q != sr_q[6:0]);
                        index_err_d = !long_q && !no_crc_q && (sr_q[44:39] != cmd_idx_q);
                        frame_err_d = trans_err_q || !rsp_ser_i;
                    end else begin
                        sr_d      = {sr_q[125:0], rsp_ser_i};
                        bit_cnt_d = bit_cnt_q - 8'd1;
                        if (bit_cnt_q >= 8'd8 && bit_cnt_q <= 8'd127) crc_d = crc_next;
                        if (bit_cnt_q == (long_q ? 8'd134 : 8'd46) && rsp_ser_i) trans_err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            long_q      <= 1'b0;
            no_crc_q    <= 1'b0;
            cmd_idx_q   <= '0;
            bit_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            crc_q       <= '0;
            sr_q        <= '0;
            trans_err_q <= 1'b0;
            rsp_q       <= '0;
            crc_err_q   <= 1'b0;
            index_err_q <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            long_q      <= long_d;
            no_crc_q    <= no_crc_d;
            cmd_idx_q   <= cmd_idx_d;
            bit_cnt_q   <= bit_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            crc_q       <= crc_d;
            sr_q        <= sr_d;
            trans_err_q <= trans_err_d;
            rsp_q       <= rsp_d;
            crc_err_q   <= crc_err_d;
            index_err_q <= index_err_d;
            frame_err_q <= frame_err_d;
            timeout_q   <= timeout_d;
        end
    end

    assign busy_o      = (state_q == WAIT_START) || (state_q == RECEIVE);
    assign done_o      = (state_q == DONE);
    assign rsp_o       = rsp_q;
    assign crc_err_o   = crc_err_q;
    assign index_err_o = index_err_q;
    assign frame_err_o = frame_err_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_cmd_rsp_receiver.sv
// Self-checking bench for cmd_rsp_receiver: directed SD responses plus random frames
// compared against a frame-level reference model.
module tb_cmd_rsp_receiver;

    logic         clk_i = 1'b0;
    logic         rst_i, clk_en_i, start_listen_i, long_rsp_i, no_crc_i, rsp_ser_i;
    logic [5:0]   cmd_index_i;
    logic         busy_o, done_o, crc_err_o, index_err_o, frame_err_o, timeout_o;
    logic [127:0] rsp_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit gap_mode = 1'b0;

    always #5 clk_i = ~clk_i;

    cmd_rsp_receiver dut (
        .clk_i(clk_i), .rst_i(rst_i), .clk_en_i(clk_en_i), .start_listen_i(start_listen_i),
        .long_rsp_i(long_rsp_i), .no_crc_i(no_crc_i), .cmd_index_i(cmd_index_i),
        .rsp_ser_i(rsp_ser_i), .busy_o(busy_o), .done_o(done_o), .rsp_o(rsp_o),
        .crc_err_o(crc_err_o), .index_err_o(index_err_o), .frame_err_o(frame_err_o),
        .timeout_o(timeout_o)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [135:0] fr, input int hi);
        logic [6:0] c = '0;
        logic       f;
        for (int i = hi; i >= 8; i--) begin
            f = fr[i] ^ c[6];
            c = {c[5:3], c[2] ^ f, c[1:0], f};
        end
        return c;
    endfunction

    // Disabled cycles carry random line and start values, which must all be ignored.
    task automatic gaps();
        if (gap_mode) begin
            for (int g = 0; g < 2; g++) begin
                clk_en_i = 1'b0; rsp_ser_i = 1'($urandom); start_listen_i = 1'($urandom);
                @(posedge clk_i); @(negedge clk_i);
            end
        end
        start_listen_i = 1'b0;
    endtask

    // One enabled edge while busy; a stray start_listen_i must have no effect.
    task automatic drive_bit(input logic b);
        rsp_ser_i = b; clk_en_i = 1'b1; start_listen_i = 1'($urandom);
        @(posedge clk_i); @(negedge clk_i);
        start_listen_i = 1'b0;
        gaps();
    endtask

    task automatic arm(input bit lng, input bit ncrc, input logic [5:0] idx);
        start_listen_i = 1'b1; clk_en_i = 1'b1; rsp_ser_i = 1'b1;
        long_rsp_i = lng; no_crc_i = ncrc; cmd_index_i = idx;
        @(posedge clk_i); @(negedge clk_i);
        start_listen_i = 1'b0;
        long_rsp_i = 1'($urandom); no_crc_i = 1'($urandom); cmd_index_i = 6'($urandom);
        gaps();
    endtask

    task automatic run_txn(input string tag, input logic [135:0] fr, input bit lng, input bit ncrc,
                           input logic [5:0] idx, input int idle);
        int           n     = lng ? 136 : 48;
        int           n_idle = (idle > 64) ? 64 : idle;
        logic [127:0] e_rsp;
        bit           e_ce, e_ie, e_fe, e_to;

        e_to  = (idle >= 64);
        e_rsp = e_to ? '0 : (lng ? {8'b0, fr[127:8]} : {96'b0, fr[39:8]});
        e_ce  = !e_to && !ncrc && (crc7(fr, lng ? 127 : 47) != fr[7:1]);
        e_ie  = !e_to && !lng && !ncrc && (fr[45:40] != idx);
        e_fe  = !e_to && ((fr[n-2] != 1'b0) || (fr[0] != 1'b1));

        arm(lng, ncrc, idx);
        check({tag, ".busy_armed"}, 128'(busy_o), 128'd1);
        for (int i = 0; i < n_idle; i++) begin
            drive_bit(1'b1);
            if (i == 62) check({tag, ".done_at_63_ones"}, 128'(done_o), 128'd0);
        end
        if (!e_to) begin
            for (int i = n - 1; i >= 0; i--) drive_bit(fr[i]);
        end
        check({tag, ".done"}, 128'(done_o), 128'd1);
        check({tag, ".busy_done"}, 128'(busy_o), 128'd0);
        check({tag, ".rsp"}, rsp_o, e_rsp);
        check({tag, ".crc_err"}, 128'(crc_err_o), 128'(e_ce));
        check({tag, ".index_err"}, 128'(index_err_o), 128'(e_ie));
        check({tag, ".frame_err"}, 128'(frame_err_o), 128'(e_fe));
        check({tag, ".timeout"}, 128'(timeout_o), 128'(e_to));
        // One more enabled period: DONE drops, results stay.
        rsp_ser_i = 1'b1; clk_en_i = 1'b1; start_listen_i = 1'b0;
        @(posedge clk_i); @(negedge clk_i);
        check({tag, ".done_gone"}, 128'(done_o), 128'd0);
        check({tag, ".rsp_hold"}, rsp_o, e_rsp);
    endtask

    initial begin
        logic [135:0] fr;
        logic [47:0]  r7;
        bit           lng, ncrc;
        logic [5:0]   idx;
        int           idle;

        rst_i = 1'b1; clk_en_i = 1'b0; start_listen_i = 1'b1; long_rsp_i = 1'b0;
        no_crc_i = 1'b0; cmd_index_i = '0; rsp_ser_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("reset.busy", 128'(busy_o), 128'd0);
        check("reset.done", 128'(done_o), 128'd0);
        check("reset.rsp", rsp_o, 128'd0);
        check("reset.flags", 128'({crc_err_o, index_err_o, frame_err_o, timeout_o}), 128'd0);
        rst_i = 1'b0; start_listen_i = 1'b0;

        r7 = 48'h08_000001AA_13;
        fr = 136'(r7);
        run_txn("r7", fr, 1'b0, 1'b0, 6'd8, 5);
        check("r7.arg", 128'(rsp_o[31:0]), 128'h1AA);
        check("r7.flags", 128'({crc_err_o, index_err_o, frame_err_o, timeout_o}), 128'd0);

        fr = 136'(48'h08_000001AB_13);
        run_txn("r7_badarg", fr, 1'b0, 1'b0, 6'd8, 5);
        check("r7_badarg.crc", 128'({crc_err_o, index_err_o, frame_err_o}), 128'b100);

        fr = 136'(r7);
        run_txn("r7_idx9", fr, 1'b0, 1'b0, 6'd9, 5);
        check("r7_idx9.idx", 128'({crc_err_o, index_err_o, frame_err_o}), 128'b010);

        fr = 136'(48'h08_000001AA_12);
        run_txn("r7_endbit", fr, 1'b0, 1'b0, 6'd8, 5);
        check("r7_endbit.fe", 128'({crc_err_o, index_err_o, frame_err_o}), 128'b001);

        run_txn("timeout64", 136'(r7), 1'b0, 1'b0, 6'd8, 64);
        check("timeout64.to", 128'(timeout_o), 128'd1);
        run_txn("ones63", 136'(r7), 1'b0, 1'b0, 6'd8, 63);
        check("ones63.arg", 128'(rsp_o[31:0]), 128'h1AA);

        fr = 136'(48'h3F_80FF8000_FF);
        run_txn("r3", fr, 1'b0, 1'b1, 6'd41, 3);
        check("r3.arg", 128'(rsp_o[31:0]), 128'h80FF8000);
        check("r3.flags", 128'({crc_err_o, index_err_o, frame_err_o, timeout_o}), 128'd0);
        gap_mode = 1'b1;
        run_txn("r3_gap", fr, 1'b0, 1'b1, 6'd41, 3);
        check("r3_gap.arg", 128'(rsp_o[31:0]), 128'h80FF8000);
        run_txn("r7_gap", 136'(r7), 1'b0, 1'b0, 6'd8, 5);
        gap_mode = 1'b0;

        // Reset 20 bits into a frame, with clk_en low and a start request pending.
        arm(1'b0, 1'b0, 6'd8);
        for (int i = 0; i < 5; i++) drive_bit(1'b1);
        for (int i = 47; i > 27; i--) drive_bit(r7[i]);
        check("pre_rst.busy", 128'(busy_o), 128'd1);
        rst_i = 1'b1; clk_en_i = 1'b0; start_listen_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        clk_en_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        check("rst_mid.busy", 128'(busy_o), 128'd0);
        check("rst_mid.done", 128'(done_o), 128'd0);
        check("rst_mid.rsp", rsp_o, 128'd0);
        rst_i = 1'b0; start_listen_i = 1'b0;
        @(posedge clk_i); @(negedge clk_i);
        check("rst_mid.idle", 128'(busy_o), 128'd0);
        run_txn("after_rst", 136'(r7), 1'b0, 1'b0, 6'd8, 5);

        for (int t = 0; t < 30; t++) begin
            lng  = 1'($urandom);
            ncrc = ($urandom_range(0, 4) == 0);
            idx  = 6'($urandom);
            idle = ($urandom_range(0, 9) == 0) ? 64 + $urandom_range(0, 3) : $urandom_range(0, 40);
            gap_mode = ($urandom_range(0, 2) == 0);
            for (int b = 0; b < 136; b++) fr[b] = 1'($urandom);
            if (lng) begin
                fr[135] = 1'b0;
                fr[134] = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 3) != 0) fr[7:1] = crc7(fr, 127);
            end else begin
                fr[135:48] = '0;
                fr[47] = 1'b0;
                fr[46] = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 3) != 0) fr[45:40] = idx;
                if ($urandom_range(0, 3) != 0) fr[7:1] = crc7(fr, 47);
            end
            fr[0] = ($urandom_range(0, 7) != 0);
            run_txn($sformatf("rand%0d", t), fr, lng, ncrc, idx, idle);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_rsp_receiver.md
CMD_RSP_RECEIVER -- requirements
Module: cmd_rsp_receiver

Interface
REQ-001 SHALL have clk_i  input  1  sole clock; all flops on rising edge.
REQ-002 SHALL have rst_i  input  1  synchronous, active-high reset.
REQ-003 SHALL have clk_en_i  input  1  SD-clock qualifier; state, counters, shift register and CRC advance only on clk_i edges with clk_en_i=1.
REQ-004 SHALL have start_listen_i  input  1  arm receiver for one response.
REQ-005 SHALL have long_rsp_i  input  1  1 = 136-bit R2, 0 = 48-bit; sampled with start_listen_i.
REQ-006 SHALL have no_crc_i  input  1  1 = skip CRC and index checks (R3); sampled with start_listen_i.
REQ-007 SHALL have cmd_index_i  input  6  expected command index; sampled with start_listen_i.
REQ-008 SHALL have rsp_ser_i  input  1  CMD line, already synchronised.
REQ-009 SHALL have busy_o  output  1  high from acceptance of start_listen_i until DONE.
REQ-010 SHALL have done_o  output  1  high while state is DONE.
REQ-011 SHALL have rsp_o  output  128  response content; crc_err_o, index_err_o, frame_err_o, timeout_o  output  1 each  status.

Function
REQ-012 SHALL implement states IDLE, WAIT_START, RECEIVE, DONE.
REQ-013 IDLE: start_listen_i=1 on an enabled edge -> WAIT_START; clear status, rsp_o, bit counter, timeout counter and CRC register to 0.
REQ-014 SHALL ignore start_listen_i outside IDLE and DONE.
REQ-015 WAIT_START: each enabled edge samples rsp_ser_i; a 0 is the start bit (frame bit 47, or 135 long) and moves the state to RECEIVE.
REQ-016 WAIT_START: if 64 consecutive samples are all 1, move to DONE with timeout_o=1, rsp_o=0 and the other flags 0.
REQ-017 RECEIVE: shift in exactly 47 further bits (short) or 135 further bits (long), MSB first, one per enabled edge; the edge sampling the end bit (frame bit 0) moves the state to DONE.
REQ-018 CRC7 SHALL use polynomial x^7+x^3+1 with initial value 0 and update serially, msb-feedback form: fb = bit ^ crc[6]; crc = {crc[5:3], crc[2]^fb, crc[1:0], fb}.
REQ-019 CRC input range: short = frame bits 47..8, including the start bit; long = frame bits 127..8.
REQ-020 The received CRC field SHALL be frame bits 7..1; crc_err_o = computed != received, forced to 0 when no_crc_i=1.
REQ-021 Short response: index_err_o = (frame[45:40] != cmd_index_i), forced to 0 when no_crc_i=1; long response: index_err_o = 0.
REQ-022 frame_err_o SHALL be 1 if transmission bit (frame bit 46 short / 134 long) != 0 or end bit != 1.
REQ-023 rsp_o: short = {96'b0, frame[39:8]}; long = {8'b0, frame[127:8]}.
REQ-024 rsp_o and all status bits SHALL be stable from DONE entry until the next accepted start_listen_i.
REQ-025 DONE lasts exactly one enabled period, then returns to IDLE; start_listen_i=1 in DONE goes directly to WAIT_START.
REQ-026 With clk_en_i=0, all state SHALL hold and rsp_ser_i SHALL be ignored.
REQ-027 busy_o SHALL be 1 in WAIT_START and RECEIVE, and 0 otherwise.

Reset
REQ-028 rst_i=1 at any clock edge, including mid-receive, SHALL force state IDLE, regardless of clk_en_i.
REQ-029 rst_i=1 SHALL force rsp_o=0, all flags 0, busy_o=0, done_o=0 and all counters and the CRC register to 0.
REQ-030 With rst_i=1, start_listen_i SHALL be ignored.

Verification
REQ-031 Short R7: cmd_index_i=8, 5 idle 1s, then frame 0x08_000001AA_13 -> done_o after the end bit, rsp_o[31:0]=0x000001AA, all flags 0.
REQ-032 Same frame with argument 0x000001AB -> crc_err_o=1, index_err_o=0, frame_err_o=0; second run with cmd_index_i=9 and the original frame -> index_err_o=1, crc_err_o=0.
REQ-033 Original frame with end bit 0 (0x08_000001AA_12) -> frame_err_o=1, crc_err_o=0.
REQ-034 rsp_ser_i held 1 for 64 samples -> timeout_o=1, done_o; 63 ones then the frame from REQ-031 -> normal completion.
REQ-035 R3 with no_crc_i=1, frame 0x3F_80FF8000_FF -> rsp_o[31:0]=0x80FF8000, all flags 0; clk_en_i toggling 1-of-3 gives identical results.
REQ-036 rst_i pulsed after 20 received bits -> IDLE, outputs 0; the next start_listen_i plus a full frame completes correctly.
